// File: rtl/pam_pkg.sv
// rtl/pam_pkg.sv - shared PAM level/threshold helpers for the decision slicer
package pam_pkg;

    localparam int PAM_DEF_LEVELS = 4;
    localparam int SYM_W          = $clog2(PAM_DEF_LEVELS);

    // Ideal level k, symmetric about zero; sep is even so sep/2 is exact.
    function automatic int pam_level(input int k, input int levels, input int sep);
        return (2 * k - (levels - 1)) * (sep / 2);
    endfunction

    // Decision boundary between level j and level j+1.
    function automatic int pam_threshold(input int j, input int levels, input int sep);
        return (2 * j - (levels - 2)) * (sep / 2);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/pam_slicer.sv
// rtl/pam_slicer.sv - PAM-N decision slicer: symbol, feedback level, error, large-error count
module pam_slicer
    import pam_pkg::*;
#(
    parameter int PULSE_RESPONSE_LENGTH = 2,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int LEVELS                = 4,
    parameter int SYMBOL_SEPERATION     = 56,
    parameter int GRAY_EN               = 1,
    parameter int ERR_THRESH            = 20,
    parameter int CNT_WIDTH             = 16
) (
    input  logic                                                  clk,
    input  logic                                                  rstn,
    input  logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0] estimation,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    output logic                                                  out_valid,
    input  logic                                                  out_ready,
    output logic [$clog2(LEVELS)-1:0]                             out_sym,
    output logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0] out_level,
    output logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH:0]   out_err,
    output logic [CNT_WIDTH-1:0]                                  err_cnt,
    input  logic                                                  err_cnt_clr
);

    localparam int W  = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH;
    localparam int SW = $clog2(LEVELS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic signed [W:0]    TH_P    = (W+1)'(ERR_THRESH);
    localparam logic signed [W:0]    TH_N    = -TH_P;

    logic signed [W:0]     est_x;
    logic [LEVELS-2:0]     ge;
    logic [SW-1:0]         dec_k;
    logic signed [W-1:0]   lvl_tab [LEVELS];
    logic [SW-1:0]         sym_tab [LEVELS];

    logic                  adv;
    logic signed [W-1:0]   s1_level;
    logic signed [W:0]     s1_err;
    logic                  s1_big;

    logic                  s1_valid_d, s1_valid_q;
    logic signed [W-1:0]   s1_est_d, s1_est_q;
    logic [SW-1:0]         s1_k_d, s1_k_q;
    logic                  out_valid_d, out_valid_q;
    logic [SW-1:0]         out_sym_d, out_sym_q;
    logic signed [W-1:0]   out_level_d, out_level_q;
    logic signed [W:0]     out_err_d, out_err_q;
    logic [CNT_WIDTH-1:0]  err_cnt_d, err_cnt_q;

    assign est_x = {estimation[W-1], estimation};

    // One comparator per boundary; ties land on the upper level via >=.
    for (genvar j = 0; j < LEVELS - 1; j++) begin : g_cmp
        localparam logic signed [W:0] TJ = (W+1)'(pam_threshold(j, LEVELS, SYMBOL_SEPERATION));
        assign ge[j] = (est_x >= TJ);
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_tab
        assign lvl_tab[k] = W'(pam_level(k, LEVELS, SYMBOL_SEPERATION));
        assign sym_tab[k] = (GRAY_EN != 0) ? SW'(bin2gray(32'(k))) : SW'(k);
    end

    always_comb begin
        dec_k = '0;
        for (int j = 0; j < LEVELS - 1; j++) begin
            dec_k = dec_k + SW'(ge[j]);
        end
    end

    always_comb begin
        adv      = out_ready || !out_valid_q;
        s1_level = lvl_tab[s1_k_q];
        s1_err   = {s1_est_q[W-1], s1_est_q} - {s1_level[W-1], s1_level};
        s1_big   = (s1_err > TH_P) || (s1_err < TH_N);

        s1_valid_d  = s1_valid_q;
        s1_est_d    = s1_est_q;
        s1_k_d      = s1_k_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_level_d = out_level_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;

        // Single shared enable: the whole pipe either advances or freezes.
        if (adv) begin
            s1_valid_d  = in_valid;
            s1_est_d    = estimation;
            s1_k_d      = dec_k;
            out_valid_d = s1_valid_q;
            out_sym_d   = sym_tab[s1_k_q];
            out_level_d = s1_level;
            out_err_d   = s1_err;
        end

        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (adv && s1_valid_q && s1_big && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_est_q    <= '0;
            s1_k_q      <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_level_q <= '0;
            out_err_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_est_q    <= s1_est_d;
            s1_k_q      <= s1_k_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_level_q <= out_level_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_level = out_level_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pam_slicer.sv
// tb/tb_pam_slicer.sv - scoreboard bench for pam_slicer (PAM4 Gray and PAM2 binary instances)
module tb_pam_slicer;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic signed [15:0] est = '0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               clr = 1'b0;
    bit                 mon_en = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic               ir0, ov0, ir1, ov1;
    logic [1:0]         sym0;
    logic [0:0]         sym1;
    logic signed [15:0] lvl0, lvl1;
    logic signed [16:0] err0, err1;
    logic [3:0]         cnt0;
    logic [15:0]        cnt1;

    pam_slicer #(
        .PULSE_RESPONSE_LENGTH(2), .SIGNAL_RESOLUTION(8), .LEVELS(4),
        .SYMBOL_SEPERATION(56), .GRAY_EN(1), .ERR_THRESH(20), .CNT_WIDTH(4)
    ) u_pam4 (
        .clk(clk), .rstn(rstn), .estimation(est), .in_valid(in_valid), .in_ready(ir0),
        .out_valid(ov0), .out_ready(out_ready), .out_sym(sym0), .out_level(lvl0),
        .out_err(err0), .err_cnt(cnt0), .err_cnt_clr(clr)
    );

    pam_slicer #(
        .PULSE_RESPONSE_LENGTH(2), .SIGNAL_RESOLUTION(8), .LEVELS(2),
        .SYMBOL_SEPERATION(56), .GRAY_EN(0), .ERR_THRESH(20), .CNT_WIDTH(16)
    ) u_pam2 (
        .clk(clk), .rstn(rstn), .estimation(est), .in_valid(in_valid), .in_ready(ir1),
        .out_valid(ov1), .out_ready(out_ready), .out_sym(sym1), .out_level(lvl1),
        .out_err(err1), .err_cnt(cnt1), .err_cnt_clr(clr)
    );

    wire        dut_ir [2];
    wire        dut_ov [2];
    wire [31:0] dut_sym [2];
    wire [31:0] dut_lvl [2];
    wire [31:0] dut_err [2];
    wire [31:0] dut_cnt [2];

    assign dut_ir[0]  = ir0;
    assign dut_ir[1]  = ir1;
    assign dut_ov[0]  = ov0;
    assign dut_ov[1]  = ov1;
    assign dut_sym[0] = {30'b0, sym0};
    assign dut_sym[1] = {31'b0, sym1};
    assign dut_lvl[0] = {{16{lvl0[15]}}, lvl0};
    assign dut_lvl[1] = {{16{lvl1[15]}}, lvl1};
    assign dut_err[0] = {{15{err0[16]}}, err0};
    assign dut_err[1] = {{15{err1[16]}}, err1};
    assign dut_cnt[0] = {28'b0, cnt0};
    assign dut_cnt[1] = {16'b0, cnt1};

    typedef struct {
        int sym;
        int lvl;
        int err;
        bit big;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int  lv_n   [2] = '{4, 2};
    bit  gray_n [2] = '{1'b1, 1'b0};
    int  cmax   [2] = '{15, 65535};
    bit  exp_ov [2] = '{1'b0, 1'b0};
    bit  s1_occ [2] = '{1'b0, 1'b0};
    int  cnt_m  [2] = '{0, 0};

    // Nearest ideal level with ties rounding up, clamped to the constellation.
    function automatic exp_t model(input int e, input int levels, input bit gray);
        exp_t r;
        int   k;
        k = int'($floor(real'(e) / 56.0 + real'(levels) / 2.0));
        if (k < 0) k = 0;
        if (k > levels - 1) k = levels - 1;
        r.lvl = (2 * k - (levels - 1)) * 28;
        r.err = e - r.lvl;
        r.sym = gray ? (k ^ (k >> 1)) : k;
        r.big = (r.err > 20) || (r.err < -20);
        return r;
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_front(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_pop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void q_push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic void q_clear(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the visible state against the model, then advances the model
    // by what the coming clock edge will do.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit   adv;
            exp_t e;
            if (mon_en) begin
                chk($sformatf("in_ready[%0d]", d), int'(dut_ir[d]), int'(out_ready || !exp_ov[d]));
                chk($sformatf("out_valid[%0d]", d), int'(dut_ov[d]), int'(exp_ov[d]));
                chk($sformatf("err_cnt[%0d]", d), int'(dut_cnt[d]), cnt_m[d]);
            end
            adv = out_ready || !exp_ov[d];
            if (mon_en && exp_ov[d] && out_ready) begin
                if (q_size(d) == 0) begin
                    chk($sformatf("sb_nonempty[%0d]", d), 0, 1);
                end else begin
                    e = q_front(d);
                    q_pop(d);
                    chk($sformatf("out_sym[%0d]", d), int'(dut_sym[d]), e.sym);
                    chk($sformatf("out_level[%0d]", d), int'(dut_lvl[d]), e.lvl);
                    chk($sformatf("out_err[%0d]", d), int'(dut_err[d]), e.err);
                end
            end
            if (!rstn) begin
                q_clear(d);
                exp_ov[d] = 1'b0;
                s1_occ[d] = 1'b0;
                cnt_m[d]  = 0;
            end else begin
                if (clr) begin
                    cnt_m[d] = 0;
                end else if (adv && s1_occ[d] && q_size(d) > 0) begin
                    e = q_front(d);
                    if (e.big && cnt_m[d] < cmax[d]) cnt_m[d]++;
                end
                if (adv) begin
                    exp_ov[d] = s1_occ[d];
                    s1_occ[d] = in_valid;
                    if (in_valid) q_push(d, model(int'(est), lv_n[d], gray_n[d]));
                end
            end
        end
    end

    task automatic drive(input int e, input bit v, input bit r, input bit c);
        est       = 16'(e);
        in_valid  = v;
        out_ready = r;
        clr       = c;
        @(posedge clk);
        #1;
    endtask

    int dir_vals [8] = '{30, 0, -56, 56, -200, -1, 0, 85};

    initial begin
        rstn = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (2) drive(0, 0, 1, 0);
        rstn = 1'b1;

        foreach (dir_vals[i]) drive(dir_vals[i], 1, 1, 0);
        drive(-200, 1, 1, 0);
        drive(-200, 1, 1, 1);
        drive(-200, 1, 1, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 1, 0);

        for (int i = 0; i < 10; i++) drive(i, 1, !(i >= 3 && i <= 5), 0);
        repeat (3) drive(0, 0, 1, 0);

        repeat (20) drive(200, 1, 1, 0);
        repeat (3) drive(0, 0, 1, 0);
        @(negedge clk);
        chk("pam4_cnt_saturated", int'(cnt0), 15);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 1);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rstn = 1'b0;
                drive(int'($urandom_range(300)) - 150, 1, 1, 0);
                rstn = 1'b1;
            end else begin
                drive(int'($urandom_range(300)) - 150,
                      ($urandom_range(3) != 0),
                      ($urandom_range(3) != 0),
                      ($urandom_range(31) == 0));
            end
        end

        repeat (6) drive(0, 0, 1, 0);
        chk("pam4_sb_drained", q_size(0), 0);
        chk("pam2_sb_drained", q_size(1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pam_slicer.md
Name: pam_slicer

Overview:
- Parametrised PAM-N decision slicer in the RX DFE path. Next generation of the fixed 4-level decision block.
- Takes equalised soft estimates and outputs the decided symbol index, optionally Gray-coded.
- Also outputs the reconstructed ideal level for DFE feedback and the signed slicer error for LMS adaptation.
- 2-stage pipeline with valid/ready handshake on both sides, plus a saturating large-error counter for link-quality monitoring.

Parameters:
- PULSE_RESPONSE_LENGTH, 2, with SIGNAL_RESOLUTION sets estimate width W = SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH
- SIGNAL_RESOLUTION, 8, bits per tap
- LEVELS, 4, PAM order; power of two, 2..16
- SYMBOL_SEPERATION, 56, spacing between adjacent ideal levels; even, positive
- GRAY_EN, 1, 1 = out_sym is Gray-coded index, 0 = binary index
- ERR_THRESH, 20, |error| strictly above this counts as a large error
- CNT_WIDTH, 16, large-error counter width

Ports:
- clk  input  1  clock
- rstn  input  1  synchronous active-low reset
- estimation  input  W signed  soft estimate
- in_valid  input  1  estimate valid
- in_ready  output  1  slicer can accept
- out_valid  output  1  decision valid
- out_ready  input  1  consumer accepts
- out_sym  output  $clog2(LEVELS)  decided symbol (binary or Gray)
- out_level  output  W signed  ideal level of decided symbol (feedback value)
- out_err  output  W+1 signed  estimation minus out_level
- err_cnt  output  CNT_WIDTH  saturating large-error count
- err_cnt_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Reset is synchronous, active-low, on rstn; clock clk. While rstn=0, all stage valids, out_valid, out_sym, out_level, out_err and err_cnt are 0.
- Ideal levels: L_k = (2k-(LEVELS-1))*SYMBOL_SEPERATION/2, k=0..LEVELS-1. Example, PAM4 with SEP=56: -84, -28, 28, 84.
- Thresholds: T_j = (2j-(LEVELS-2))*SYMBOL_SEPERATION/2, j=0..LEVELS-2.
- Decision index k = number of thresholds with estimation >= T_j.
  - Ties (estimation exactly on a threshold) resolve to the upper level.
  - No invalid or "no decision" outcome exists; out-of-range inputs clamp to k=0 or k=LEVELS-1.
- All comparisons and subtraction are signed, done at W+1 bits. out_err is never truncated.
- Stage 1 registers the estimate and index k. Stage 2 registers out_sym, out_level and out_err.
- Global advance enable: adv = out_ready || !out_valid.
  - Both stages shift only when adv=1. in_ready = adv (combinational, no dependence on in_valid).
  - A stage loads its upstream valid on adv, so bubbles collapse only by draining.
- Latency: an estimate accepted on edge n appears at out_valid on edge n+2 when adv holds.
- Stall: with out_ready=0 and out_valid=1, outputs and both stages hold exactly and in_ready=0. No sample is lost or duplicated. Throughput is 1 symbol/cycle when out_ready=1.
- Gray mapping: g = k ^ (k>>1) when GRAY_EN=1.
- err_cnt:
  - Increments by 1 when stage 2 loads a valid symbol with |out_err| > ERR_THRESH.
  - Saturates at all-ones; never wraps.
  - err_cnt_clr has priority over increment in the same cycle; the count is 0 next cycle.
- Reset asserted mid-stream flushes both stages; in-flight samples are discarded.

Decomposition:
- Shared package pam_pkg holds:
  - function pam_level(k, LEVELS, SEP)
  - function pam_threshold(j, LEVELS, SEP)
  - function bin2gray
  - localparam SYM_W = $clog2(LEVELS)
- No sub-module: the counter and pipeline are inline. The threshold compare is a generate loop over LEVELS-1 comparators feeding a popcount.

Test Plan:
- PAM4, SEP=56, out_ready=1, estimation=30 -> after 2 cycles: out_sym=3 (Gray of 2), out_level=28, out_err=+2, err_cnt unchanged.
- estimation=0, then -56, then 56 (tie cases) -> out_level = 28, -28, 84 respectively, in consecutive cycles.
- estimation=-200, ERR_THRESH=20 -> out_sym=0, out_level=-84, out_err=-116, err_cnt 0->1. Then err_cnt_clr asserted together with another large error -> err_cnt=0.
- Continuous in_valid with ramp 0..9, out_ready low for cycles 3-5:
  - in_ready falls with it; out_valid/out_sym hold.
  - All 10 results emerge in order, none duplicated.
- CNT_WIDTH=4, 20 consecutive estimates of +200 -> err_cnt stops at 15.
- LEVELS=2, GRAY_EN=0 -> estimation=-1 gives out_sym=0, level -28; estimation=0 gives out_sym=1, level 28.
- rstn low for 1 cycle mid-stream -> out_valid=0 next cycle, err_cnt=0, and the first new sample appears 2 cycles after acceptance.
